sel_decode_32: RTL and testbench
================================

SEL_DECODE_32 -- requirements
Module: sel_decode_32

Interface
REQ-001 SHALL have parameter PULSE_LEN, default 1, the number of cycles select outputs are held; legal range 1..15.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port clr_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port ir, input, 32, instruction word; Ra=ir[26:22], Rb=ir[21:17], Rc=ir[16:12].
REQ-005 SHALL have ports gra, grb, grc, input, 1 each, selecting which field is decoded.
REQ-006 SHALL have ports r_in, r_out, ba_out, input, 1 each, selecting which select bus is driven.
REQ-007 SHALL have port req, input, 1, decode request; it is accepted only when ready=1.
REQ-008 SHALL have port ready, output, 1, high only in IDLE.
REQ-009 SHALL have port reg_in_sel, output, 32, one-hot register write-enable bus.
REQ-010 SHALL have port reg_out_sel, output, 32, one-hot register read-enable bus.
REQ-011 SHALL have port c_sext, output, 32, sign-extended immediate {{15{ir[16]}}, ir[16:0]}.
REQ-012 SHALL have port r0_zero, output, 1, high when ba_out selects index 0.
REQ-013 SHALL have ports ack and err, output, 1 each, single-cycle completion and rejection pulses.

Function
REQ-014 SHALL implement FSM states IDLE and ACTIVE plus a 4-bit hold counter.
REQ-015 SHALL accept a request at a rising edge where state=IDLE and req=1.
REQ-016 SHALL, on acceptance, latch ir, gra/grb/grc and r_in/r_out/ba_out; later changes to these inputs SHALL NOT affect the current operation.
REQ-017 SHALL, when exactly one of gra/grb/grc is high, enter ACTIVE and load counter=PULSE_LEN.
REQ-018 SHALL, when zero or more than one of gra/grb/grc is high, stay in IDLE, pulse err for one cycle, and leave all selects at zero.
REQ-019 SHALL decode the chosen 5-bit index n into a 32-bit one-hot word with bit n set.
REQ-020 SHALL register all outputs: selects become valid in the first cycle after acceptance, with latency 1.
REQ-021 SHALL, in ACTIVE, drive reg_in_sel=onehot if r_in was latched, otherwise 0.
REQ-022 SHALL, in ACTIVE, drive reg_out_sel=onehot if r_out or ba_out was latched, otherwise 0.
REQ-023 SHALL, when ba_out was latched and n=0, hold reg_out_sel=0 and r0_zero=1 for the whole ACTIVE window.
REQ-024 SHALL drive both buses simultaneously when r_in and r_out were both latched.
REQ-025 SHALL, when none of r_in/r_out/ba_out was latched, still run the ACTIVE window with both buses at zero.
REQ-026 SHALL decrement the counter each ACTIVE cycle, assert ack in the last ACTIVE cycle (counter=1), and return to IDLE on the next edge with all selects cleared.
REQ-027 SHALL ignore req while ACTIVE, including in the ack cycle; ready SHALL return high the cycle after ack.
REQ-028 SHALL update c_sext every cycle from the latched ir and hold it unchanged while in IDLE.

Reset
REQ-029 SHALL, while clr_n=0, force: state=IDLE, counter=0, ready=1, reg_in_sel=0, reg_out_sel=0, c_sext=0, r0_zero=0, ack=0, err=0.
REQ-030 SHALL abort an ACTIVE operation immediately on reset with no ack; the first request after release SHALL be accepted normally.

Structure
REQ-031 SHALL place the following in package sel_decode_pkg: field bit-position constants, the state type (IDLE/ACTIVE), and PULSE_LEN limits.
REQ-032 SHALL instantiate a combinational sub-module dec_5_32 (5-bit index in, 32-bit one-hot out).

Verification
REQ-033 SHALL cover: ir=32'h0140_0000 (Ra=5), gra=1, r_in=1, req for one cycle -> next cycle reg_in_sel=32'h0000_0020 and ack=1; the cycle after, reg_in_sel=0 and ready=1.
REQ-034 SHALL cover: PULSE_LEN=3, Rc=31, grc=1, r_out=1 -> reg_out_sel=32'h8000_0000 for exactly 3 cycles, with ack in the 3rd.
REQ-035 SHALL cover: gra=grb=1, req -> err pulses once, selects stay 0, and ready stays 1.
REQ-036 SHALL cover: Rb=0, grb=1, ba_out=1 -> reg_out_sel=0 and r0_zero=1 for the window.
REQ-037 SHALL cover: ir[16:0]=17'h1_0000 -> c_sext=32'hFFFF_0000, and ir[16:0]=17'h0_7FFF -> c_sext=32'h0000_7FFF.
REQ-038 SHALL cover: PULSE_LEN=4, clr_n pulled low in the 2nd ACTIVE cycle -> all outputs 0 at once, no ack, and a new req after release succeeds.

Source files
------------

// File: rtl/sel_decode_pkg.sv
// Shared constants, state encoding and field helpers for the sel_decode_32 register-select decoder.
package sel_decode_pkg;

  localparam int unsigned FIELD_W       = 5;
  localparam int unsigned RA_LSB        = 22;
  localparam int unsigned RB_LSB        = 17;
  localparam int unsigned RC_LSB        = 12;
  localparam int unsigned RA_MSB        = RA_LSB + FIELD_W - 1;
  localparam int unsigned RB_MSB        = RB_LSB + FIELD_W - 1;
  localparam int unsigned RC_MSB        = RC_LSB + FIELD_W - 1;
  localparam int unsigned IMM_MSB       = 16;
  localparam int unsigned IR_KEEP_MSB   = RA_MSB;
  localparam int unsigned CNT_W         = 4;
  localparam int unsigned PULSE_LEN_MIN = 1;
  localparam int unsigned PULSE_LEN_MAX = 15;

  typedef logic [0:0] state_t;
  localparam state_t ST_IDLE   = 1'b0;
  localparam state_t ST_ACTIVE = 1'b1;

  typedef struct packed {
    logic gra;
    logic grb;
    logic grc;
  } gr_t;

  typedef struct packed {
    logic r_in;
    logic r_out;
    logic ba_out;
  } bus_t;

  function automatic logic gr_is_onehot(input gr_t gr);
    case (gr)
      3'b100, 3'b010, 3'b001: return 1'b1;
      default:                return 1'b0;
    endcase
  endfunction

  // fields holds ir[RA_MSB:RC_LSB]: Ra in the top five bits, Rc in the bottom five.
  function automatic logic [FIELD_W-1:0] field_index(input logic [RA_MSB-RC_LSB:0] fields,
                                                     input gr_t gr);
    case (gr)
      3'b100:  return fields[RA_MSB-RC_LSB -: FIELD_W];
      3'b010:  return fields[RB_MSB-RC_LSB -: FIELD_W];
      3'b001:  return fields[RC_MSB-RC_LSB -: FIELD_W];
      default: return 5'd0;
    endcase
  endfunction

  function automatic logic [31:0] sext_imm(input logic [IMM_MSB:0] imm);
    return {{(31 - IMM_MSB){imm[IMM_MSB]}}, imm};
  endfunction

endpackage

// File: rtl/sel_decode_32_dec.sv
// Combinational 5-to-32 one-hot decoder used for the register select buses.
module dec_5_32
  import sel_decode_pkg::*;
(
  input  logic [FIELD_W-1:0] idx_i,
  output logic [31:0]        onehot_o
);

  assign onehot_o = 32'h0000_0001 << idx_i;

endmodule

// File: rtl/sel_decode_32.sv
// Register-select decoder: latches an instruction on request, then drives one-hot
// read/write select buses for PULSE_LEN cycles and signals completion with ack.
module sel_decode_32
  import sel_decode_pkg::*;
#(
  parameter int unsigned PULSE_LEN = 1
) (
  input  logic        clk,
  input  logic        clr_n,
  input  logic [31:0] ir,
  input  logic        gra,
  input  logic        grb,
  input  logic        grc,
  input  logic        r_in,
  input  logic        r_out,
  input  logic        ba_out,
  input  logic        req,
  output logic        ready,
  output logic [31:0] reg_in_sel,
  output logic [31:0] reg_out_sel,
  output logic [31:0] c_sext,
  output logic        r0_zero,
  output logic        ack,
  output logic        err
);

  localparam logic [CNT_W-1:0] CNT_LOAD =
      (PULSE_LEN < PULSE_LEN_MIN) ? CNT_W'(PULSE_LEN_MIN) :
      (PULSE_LEN > PULSE_LEN_MAX) ? CNT_W'(PULSE_LEN_MAX) : CNT_W'(PULSE_LEN);

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [IR_KEEP_MSB:0]   ir_q, ir_d;
  gr_t                    gr_q, gr_d;
  bus_t                   bus_q, bus_d;

  logic                   ready_q, ready_d;
  logic [31:0]            reg_in_sel_q, reg_in_sel_d;
  logic [31:0]            reg_out_sel_q, reg_out_sel_d;
  logic [31:0]            c_sext_q, c_sext_d;
  logic                   r0_zero_q, r0_zero_d;
  logic                   ack_q, ack_d;
  logic                   err_q, err_d;

  logic                   accept_s;
  logic                   gr_ok_s;
  logic [FIELD_W-1:0]     idx_s;
  logic [31:0]            onehot_s;
  logic                   active_next_s;
  logic                   r0_hit_s;
  logic                   unused_ir_s;

  // Opcode bits above Ra play no part in select decoding.
  assign unused_ir_s = ^ir[31:IR_KEEP_MSB+1];

  assign accept_s = (state_q == ST_IDLE) && req;

  // Operand capture: a new instruction is taken only on acceptance, otherwise held.
  always_comb begin
    ir_d  = ir_q;
    gr_d  = gr_q;
    bus_d = bus_q;
    if (accept_s) begin
      ir_d  = ir[IR_KEEP_MSB:0];
      gr_d  = {gra, grb, grc};
      bus_d = {r_in, r_out, ba_out};
    end else begin
      ir_d  = ir_q;
      gr_d  = gr_q;
      bus_d = bus_q;
    end
  end

  assign gr_ok_s = gr_is_onehot(gr_d);
  assign idx_s   = field_index(ir_d[RA_MSB:RC_LSB], gr_d);

  dec_5_32 u_dec (
    .idx_i    (idx_s),
    .onehot_o (onehot_s)
  );

  // Sequencer: IDLE accepts requests, ACTIVE counts the hold window down to the ack cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept_s && gr_ok_s) begin
          state_d = ST_ACTIVE;
          cnt_d   = CNT_LOAD;
        end else if (accept_s) begin
          err_d   = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACTIVE: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          state_d = ST_IDLE;
          cnt_d   = 4'd0;
        end else begin
          state_d = ST_ACTIVE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  assign active_next_s = (state_d == ST_ACTIVE);
  // Index 0 via the base-address path means "constant zero", so no register is read.
  assign r0_hit_s      = bus_d.ba_out && (idx_s == 5'd0);

  // Output next-state: computed from the post-edge view so selects appear one cycle after acceptance.
  always_comb begin
    reg_in_sel_d  = 32'h0000_0000;
    reg_out_sel_d = 32'h0000_0000;
    r0_zero_d     = 1'b0;
    if (active_next_s) begin
      reg_in_sel_d  = bus_d.r_in ? onehot_s : 32'h0000_0000;
      reg_out_sel_d = ((bus_d.r_out || bus_d.ba_out) && !r0_hit_s) ? onehot_s : 32'h0000_0000;
      r0_zero_d     = r0_hit_s;
    end else begin
      reg_in_sel_d  = 32'h0000_0000;
      reg_out_sel_d = 32'h0000_0000;
      r0_zero_d     = 1'b0;
    end
    ack_d    = active_next_s && (cnt_d == 4'd1);
    ready_d  = (state_d == ST_IDLE);
    c_sext_d = sext_imm(ir_d[IMM_MSB:0]);
  end

  // State, latched operands and registered outputs.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q       <= ST_IDLE;
      cnt_q         <= 4'd0;
      ir_q          <= '0;
      gr_q          <= 3'b000;
      bus_q         <= 3'b000;
      ready_q       <= 1'b1;
      reg_in_sel_q  <= 32'h0000_0000;
      reg_out_sel_q <= 32'h0000_0000;
      c_sext_q      <= 32'h0000_0000;
      r0_zero_q     <= 1'b0;
      ack_q         <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      ir_q          <= ir_d;
      gr_q          <= gr_d;
      bus_q         <= bus_d;
      ready_q       <= ready_d;
      reg_in_sel_q  <= reg_in_sel_d;
      reg_out_sel_q <= reg_out_sel_d;
      c_sext_q      <= c_sext_d;
      r0_zero_q     <= r0_zero_d;
      ack_q         <= ack_d;
      err_q         <= err_d;
    end
  end

  assign ready       = ready_q;
  assign reg_in_sel  = reg_in_sel_q;
  assign reg_out_sel = reg_out_sel_q;
  assign c_sext      = c_sext_q;
  assign r0_zero     = r0_zero_q;
  assign ack         = ack_q;
  assign err         = err_q;

endmodule

// File: tb/tb_sel_decode_32.sv
// Directed bench for sel_decode_32 with PULSE_LEN of 1, 3 and 4.
module tb_sel_decode_32;

  logic        clk = 1'b0;
  logic        clr_n;
  logic [31:0] ir;
  logic        gra, grb, grc, r_in, r_out, ba_out;
  logic        req_1, req_3, req_4;

  logic        rdy1, rdy3, rdy4, r01, r03, r04, ack1, ack3, ack4, err1, err3, err4;
  logic [31:0] in1, in3, in4, out1, out3, out4, cs1, cs3, cs4;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sel_decode_32 #(.PULSE_LEN(1)) u_p1 (
    .clk(clk), .clr_n(clr_n), .ir(ir), .gra(gra), .grb(grb), .grc(grc),
    .r_in(r_in), .r_out(r_out), .ba_out(ba_out), .req(req_1), .ready(rdy1),
    .reg_in_sel(in1), .reg_out_sel(out1), .c_sext(cs1), .r0_zero(r01), .ack(ack1), .err(err1));

  sel_decode_32 #(.PULSE_LEN(3)) u_p3 (
    .clk(clk), .clr_n(clr_n), .ir(ir), .gra(gra), .grb(grb), .grc(grc),
    .r_in(r_in), .r_out(r_out), .ba_out(ba_out), .req(req_3), .ready(rdy3),
    .reg_in_sel(in3), .reg_out_sel(out3), .c_sext(cs3), .r0_zero(r03), .ack(ack3), .err(err3));

  sel_decode_32 #(.PULSE_LEN(4)) u_p4 (
    .clk(clk), .clr_n(clr_n), .ir(ir), .gra(gra), .grb(grb), .grc(grc),
    .r_in(r_in), .r_out(r_out), .ba_out(ba_out), .req(req_4), .ready(rdy4),
    .reg_in_sel(in4), .reg_out_sel(out4), .c_sext(cs4), .r0_zero(r04), .ack(ack4), .err(err4));

  typedef struct {
    logic [31:0] ir;
    logic [2:0]  gr;      // {gra, grb, grc}
    logic [2:0]  bus;     // {r_in, r_out, ba_out}
    logic [31:0] exp_in;
    logic [31:0] exp_out;
    logic [31:0] exp_cs;
    logic        exp_r0;
    logic        exp_err;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_inputs(input logic [31:0] v_ir, input logic [2:0] v_gr, input logic [2:0] v_bus);
    ir = v_ir;
    {gra, grb, grc} = v_gr;
    {r_in, r_out, ba_out} = v_bus;
  endtask

  initial begin
    vecs[0] = '{32'h0140_0000, 3'b100, 3'b100, 32'h0000_0020, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0};
    vecs[1] = '{32'h0001_F000, 3'b001, 3'b010, 32'h0000_0000, 32'h8000_0000, 32'hFFFF_F000, 1'b0, 1'b0};
    vecs[2] = '{32'h0001_F000, 3'b110, 3'b100, 32'h0000_0000, 32'h0000_0000, 32'hFFFF_F000, 1'b0, 1'b1};
    vecs[3] = '{32'h07C0_0000, 3'b010, 3'b001, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0};
    vecs[4] = '{32'h0001_0000, 3'b001, 3'b000, 32'h0000_0000, 32'h0000_0000, 32'hFFFF_0000, 1'b0, 1'b0};
    vecs[5] = '{32'h0000_7FFF, 3'b001, 3'b110, 32'h0000_0080, 32'h0000_0080, 32'h0000_7FFF, 1'b0, 1'b0};
    vecs[6] = '{32'h0000_7FFF, 3'b000, 3'b100, 32'h0000_0000, 32'h0000_0000, 32'h0000_7FFF, 1'b0, 1'b1};
    vecs[7] = '{32'h0012_0000, 3'b010, 3'b101, 32'h0000_0200, 32'h0000_0200, 32'h0000_0000, 1'b0, 1'b0};
    vecs[8] = '{32'h0000_0000, 3'b111, 3'b010, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1};
    vecs[9] = '{32'h0000_0000, 3'b100, 3'b011, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0};

    clr_n = 1'b0;
    req_1 = 1'b0; req_3 = 1'b0; req_4 = 1'b0;
    set_inputs(32'h0000_0000, 3'b000, 3'b000);
    repeat (2) @(negedge clk);

    chk("rst ready", rdy1, 1'b1);
    chk("rst in",    in1,  32'h0);
    chk("rst out",   out1, 32'h0);
    chk("rst cs",    cs1,  32'h0);
    chk("rst r0",    r01,  1'b0);
    chk("rst ack",   ack1, 1'b0);
    chk("rst err",   err1, 1'b0);
    chk("rst ready4", rdy4, 1'b1);
    clr_n = 1'b1;
    @(negedge clk);

    // Single-cycle window: each vector is one request then two sampled cycles.
    for (int i = 0; i < 10; i++) begin
      set_inputs(vecs[i].ir, vecs[i].gr, vecs[i].bus);
      req_1 = 1'b1;
      @(negedge clk);
      req_1 = 1'b0;
      chk($sformatf("v%0d in", i),    in1,  vecs[i].exp_in);
      chk($sformatf("v%0d out", i),   out1, vecs[i].exp_out);
      chk($sformatf("v%0d cs", i),    cs1,  vecs[i].exp_cs);
      chk($sformatf("v%0d r0", i),    r01,  vecs[i].exp_r0);
      chk($sformatf("v%0d ack", i),   ack1, !vecs[i].exp_err);
      chk($sformatf("v%0d err", i),   err1, vecs[i].exp_err);
      chk($sformatf("v%0d ready", i), rdy1, vecs[i].exp_err);
      @(negedge clk);
      chk($sformatf("v%0d in2", i),    in1,  32'h0);
      chk($sformatf("v%0d out2", i),   out1, 32'h0);
      chk($sformatf("v%0d r02", i),    r01,  1'b0);
      chk($sformatf("v%0d ack2", i),   ack1, 1'b0);
      chk($sformatf("v%0d err2", i),   err1, 1'b0);
      chk($sformatf("v%0d ready2", i), rdy1, 1'b1);
      chk($sformatf("v%0d cs2", i),    cs1,  vecs[i].exp_cs);
    end

    // Three-cycle window; inputs are scrambled and req held high while active.
    set_inputs(32'h0001_F000, 3'b001, 3'b010);
    req_3 = 1'b1;
    @(negedge clk);
    set_inputs(32'h0140_0000, 3'b100, 3'b100);
    for (int k = 1; k <= 3; k++) begin
      chk($sformatf("p3 out c%0d", k),   out3, 32'h8000_0000);
      chk($sformatf("p3 in c%0d", k),    in3,  32'h0);
      chk($sformatf("p3 ack c%0d", k),   ack3, (k == 3) ? 1'b1 : 1'b0);
      chk($sformatf("p3 ready c%0d", k), rdy3, 1'b0);
      chk($sformatf("p3 cs c%0d", k),    cs3,  32'hFFFF_F000);
      @(negedge clk);
    end
    chk("p3 out end",   out3, 32'h0);
    chk("p3 ack end",   ack3, 1'b0);
    chk("p3 ready end", rdy3, 1'b1);
    chk("p3 cs end",    cs3,  32'hFFFF_F000);
    req_3 = 1'b0;
    @(negedge clk);

    // Four-cycle window aborted by reset in its second cycle, then rerun.
    set_inputs(32'h0140_0000, 3'b100, 3'b100);
    req_4 = 1'b1;
    @(negedge clk);
    req_4 = 1'b0;
    chk("p4 in c1",    in4,  32'h0000_0020);
    chk("p4 ready c1", rdy4, 1'b0);
    @(negedge clk);
    chk("p4 in c2",    in4,  32'h0000_0020);
    chk("p4 ack c2",   ack4, 1'b0);
    #2 clr_n = 1'b0;
    #1;
    chk("p4 rst in",    in4,  32'h0);
    chk("p4 rst out",   out4, 32'h0);
    chk("p4 rst cs",    cs4,  32'h0);
    chk("p4 rst r0",    r04,  1'b0);
    chk("p4 rst ack",   ack4, 1'b0);
    chk("p4 rst err",   err4, 1'b0);
    chk("p4 rst ready", rdy4, 1'b1);
    @(negedge clk);
    clr_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("p4 noack %0d", k),  ack4, 1'b0);
      chk($sformatf("p4 idle in %0d", k), in4, 32'h0);
      chk($sformatf("p4 idle rdy %0d", k), rdy4, 1'b1);
    end
    req_4 = 1'b1;
    @(negedge clk);
    req_4 = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      chk($sformatf("p4b in c%0d", k),    in4,  32'h0000_0020);
      chk($sformatf("p4b ack c%0d", k),   ack4, (k == 4) ? 1'b1 : 1'b0);
      chk($sformatf("p4b ready c%0d", k), rdy4, 1'b0);
      @(negedge clk);
    end
    chk("p4b in end",    in4,  32'h0);
    chk("p4b ack end",   ack4, 1'b0);
    chk("p4b ready end", rdy4, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
